maxpool_flatten_engine: RTL

- Parametrised successor to the CONV layer-1/layer-2 back end.
- Reads NCH layer-0 feature maps from the shared csel-addressed scratch memory.
- Performs POOL x POOL max-pooling with stride POOL, then writes one pooled map per channel.
- Optionally writes a channel-interleaved flatten vector. It sits behind the convolution stage on the same crd/cwr memory bus.

---
 rtl/maxpool_flatten_engine_if.sv | 27 ++
 rtl/maxpool_flatten_engine.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/maxpool_flatten_engine_if.sv
// Host/memory bus of the max-pool + flatten engine.
// master = engine side, slave = host and scratch memory side.
interface maxpool_flatten_engine_if #(
    parameter int DW  = 20,
    parameter int AW  = 12,
    parameter int CSW = 3
);
    logic           ready;
    logic           busy;
    logic           crd;
    logic [AW-1:0]  caddr_rd;
    logic [DW-1:0]  cdata_rd;
    logic           cwr;
    logic [AW-1:0]  caddr_wr;
    logic [DW-1:0]  cdata_wr;
    logic [CSW-1:0] csel;

    modport master (
        input  ready, cdata_rd,
        output busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        output ready, cdata_rd,
        input  busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );
endinterface

// File: rtl/maxpool_flatten_engine.sv
// POOLxPOOL max-pool of NCH layer-0 maps from scratch memory,
// writing pooled maps and an optional channel-interleaved flatten vector.
module maxpool_flatten_engine #(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int NCH        = 2,
    parameter int POOL       = 2,
    parameter int DW         = 20,
    parameter int AW         = 12,
    parameter int CSW        = 3,
    parameter int FLATTEN_EN = 1
) (
    input logic clk,
    input logic reset,
    maxpool_flatten_engine_if.master bus
);
    localparam int OW = IMG_W / POOL;
    localparam int OH = IMG_H / POOL;
    localparam logic [AW-1:0] OXL = AW'(OW - 1);
    localparam logic [AW-1:0] OYL = AW'(OH - 1);
    localparam logic [2:0] WL = 3'(POOL - 1);
    localparam logic [CSW-1:0] CL = CSW'(NCH - 1);

    typedef enum logic [2:0] {
        IDLE, READ, WAIT, WR_POOL, WR_FLAT, NEXT, DONE
    } state_t;

    state_t st, st_n;
    logic [AW-1:0] ox, ox_n, oy, oy_n, oi, oi_n;
    logic [CSW-1:0] ch, ch_n;
    logic [2:0] wx, wx_n, wy, wy_n;
    logic signed [DW-1:0] mx, mx_n;
    logic fresh, fresh_n;
    logic busy_n, crd_n, cwr_n;
    logic [AW-1:0] caddr_rd_n, caddr_wr_n;
    logic [DW-1:0] cdata_wr_n;
    logic [CSW-1:0] csel_n;

    // Next state, counters, running max and next registered outputs.
    always_comb begin
        st_n = st;
        ox_n = ox;
        oy_n = oy;
        oi_n = oi;
        ch_n = ch;
        wx_n = wx;
        wy_n = wy;
        mx_n = mx;
        fresh_n = fresh;
        busy_n = 1'b1;
        crd_n = 1'b0;
        cwr_n = 1'b0;
        caddr_rd_n = '0;
        caddr_wr_n = '0;
        cdata_wr_n = '0;
        csel_n = '0;
        // A read registered last edge returns its datum on this edge.
        if (bus.crd) begin
            if (fresh || ($signed(bus.cdata_rd) > mx))
                mx_n = bus.cdata_rd;
            fresh_n = 1'b0;
        end
        unique case (st)
            IDLE: begin
                busy_n = bus.ready;
                fresh_n = 1'b1;
                ox_n = '0;
                oy_n = '0;
                oi_n = '0;
                ch_n = '0;
                wx_n = '0;
                wy_n = '0;
                if (bus.ready)
                    st_n = READ;
            end
            READ: begin
                crd_n = 1'b1;
                csel_n = ch + CSW'(1);
                caddr_rd_n = AW'((32'(oy) * POOL + 32'(wy)) * IMG_W
                                 + 32'(ox) * POOL + 32'(wx));
                if (wx == WL) begin
                    wx_n = '0;
                    if (wy == WL) begin
                        wy_n = '0;
                        st_n = WAIT;
                    end else begin
                        wy_n = wy + 3'd1;
                    end
                end else begin
                    wx_n = wx + 3'd1;
                end
            end
            WAIT: st_n = WR_POOL;
            WR_POOL: begin
                cwr_n = 1'b1;
                csel_n = CSW'(NCH + 1) + ch;
                caddr_wr_n = oi;
                cdata_wr_n = mx;
                st_n = (FLATTEN_EN != 0) ? WR_FLAT : NEXT;
            end
            WR_FLAT: begin
                cwr_n = 1'b1;
                csel_n = CSW'(2 * NCH + 1);
                caddr_wr_n = AW'(NCH * 32'(oi) + 32'(ch));
                cdata_wr_n = mx;
                st_n = NEXT;
            end
            NEXT: begin
                fresh_n = 1'b1;
                st_n = READ;
                if (ch == CL) begin
                    ch_n = '0;
                    if ((ox == OXL) && (oy == OYL)) begin
                        ox_n = '0;
                        oy_n = '0;
                        oi_n = '0;
                        st_n = DONE;
                    end else begin
                        oi_n = oi + AW'(1);
                        if (ox == OXL) begin
                            ox_n = '0;
                            oy_n = oy + AW'(1);
                        end else begin
                            ox_n = ox + AW'(1);
                        end
                    end
                end else begin
                    ch_n = ch + CSW'(1);
                end
            end
            DONE: begin
                busy_n = 1'b0;
                st_n = IDLE;
            end
            default: begin
                busy_n = 1'b0;
                st_n = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset abandons any run.
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= IDLE;
            ox <= '0;
            oy <= '0;
            oi <= '0;
            ch <= '0;
            wx <= '0;
            wy <= '0;
            mx <= '0;
            fresh <= 1'b1;
            bus.busy <= 1'b0;
            bus.crd <= 1'b0;
            bus.cwr <= 1'b0;
            bus.caddr_rd <= '0;
            bus.caddr_wr <= '0;
            bus.cdata_wr <= '0;
            bus.csel <= '0;
        end else begin
            st <= st_n;
            ox <= ox_n;
            oy <= oy_n;
            oi <= oi_n;
            ch <= ch_n;
            wx <= wx_n;
            wy <= wy_n;
            mx <= mx_n;
            fresh <= fresh_n;
            bus.busy <= busy_n;
            bus.crd <= crd_n;
            bus.cwr <= cwr_n;
            bus.caddr_rd <= caddr_rd_n;
            bus.caddr_wr <= caddr_wr_n;
            bus.cdata_wr <= cdata_wr_n;
            bus.csel <= csel_n;
        end
    end
endmodule
